// File: rtl/lb_uart_tx_if.sv
// Start/busy handshake between the PicoBlaze output-port logic (master)
// and the UART transmitter (slave).
interface lb_uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_data, output tx_start, input tx_busy, input tx_done);
  modport slave  (input tx_data, input tx_start, output tx_busy, output tx_done);
endinterface

// File: rtl/lb_uart_tx.sv
// lb_uart_tx: serial UART transmitter (8N1 by default) with an internal
// clock-count baud divider. Frame = start, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits.
// Optional feature: define LB_UART_TX_PARITY_EN to build the PARITY state
// (even parity, or odd when PARITY_ODD=1). Without it DATA goes straight to STOP.
module lb_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          reset,
  lb_uart_tx_if.slave   bus,
  output logic          tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef LB_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Refuse to elaborate with parameters outside their legal ranges.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("lb_uart_tx: parameter out of legal range");
  end

  logic [2:0]           state_reg;
  logic [BW-1:0]        baud_reg;
  logic [2:0]           bit_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 baud_last;
`ifdef LB_UART_TX_PARITY_EN
  // Parity is computed once from the accepted word so the shift register
  // can be consumed freely during the data bits.
  logic                 parity_reg;
`endif

  assign baud_last   = (baud_reg == BAUD_LAST);
  assign tx          = tx_reg;
  assign bus.tx_busy = busy_reg;
  assign bus.tx_done = done_reg;

  // Frame sequencer: tx is loaded with the value of the bit being entered,
  // so the line is a clean register output and changes exactly at bit edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shreg_reg  <= '0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef LB_UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.tx_start) begin
            shreg_reg  <= bus.tx_data;
            baud_reg   <= '0;
            state_reg  <= START;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
`ifdef LB_UART_TX_PARITY_EN
            parity_reg <= (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (baud_last) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= DATA;
            tx_reg    <= shreg_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_reg  <= '0;
            shreg_reg <= shreg_reg >> 1;
            if (bit_reg == DATA_LAST) begin
              bit_reg   <= '0;
`ifdef LB_UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_reg <= bit_reg + 1'b1;
              tx_reg  <= shreg_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`ifdef LB_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (bit_reg == STOP_LAST) begin
              bit_reg   <= '0;
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
